// File: rtl/raster_pkg.sv
// Shared widths, fragment record and traversal state for the raster traverser.
package raster_pkg;

  localparam int unsigned COORD_W = 12;
  localparam int unsigned EDGE_W  = 25;
  localparam int unsigned DELTA_W = 17;
  localparam int unsigned AREA_W  = 24;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [EDGE_W-1:0]  w0;
    logic [EDGE_W-1:0]  w1;
    logic [EDGE_W-1:0]  w2;
    logic [AREA_W-1:0]  area;
  } fragment_t;

  typedef enum logic {
    IDLE,
    TRAVERSE
  } trav_state_e;

  function automatic logic [EDGE_W-1:0] sext_delta(input logic [DELTA_W-1:0] d);
    return {{(EDGE_W - DELTA_W){d[DELTA_W-1]}}, d};
  endfunction

endpackage

// File: rtl/edge_stepper.sv
// One edge function: row-start and current accumulators stepped by per-column/per-row deltas.
module edge_stepper
  import raster_pkg::*;
(
  input  logic               clock_i,
  input  logic               load_i,
  input  logic               step_col_i,
  input  logic               step_row_i,
  input  logic [EDGE_W-1:0]  w_init_i,
  input  logic [DELTA_W-1:0] dl_col_i,
  input  logic [DELTA_W-1:0] dl_row_i,
  output logic [EDGE_W-1:0]  w_o
);

  logic [EDGE_W-1:0]  r_w_row;
  logic [EDGE_W-1:0]  r_w_cur;
  logic [DELTA_W-1:0] r_dl_col;
  logic [DELTA_W-1:0] r_dl_row;
  logic [EDGE_W-1:0]  w_row_next;

  assign w_row_next = r_w_row + sext_delta(r_dl_row);
  assign w_o        = r_w_cur;

  // New row starts at the advanced row value; wraps freely in two's complement.
  always_ff @(posedge clock_i) begin
    if (load_i) begin
      r_w_row  <= w_init_i;
      r_w_cur  <= w_init_i;
      r_dl_col <= dl_col_i;
      r_dl_row <= dl_row_i;
    end else if (step_col_i) begin
      r_w_cur <= r_w_cur + sext_delta(r_dl_col);
    end else if (step_row_i) begin
      r_w_row <= w_row_next;
      r_w_cur <= w_row_next;
    end
  end

endmodule

// File: rtl/raster_traverse.sv
// Walks a triangle bounding box in raster order, one pixel per free output slot,
// emitting covered on-screen fragments.
module raster_traverse
  import raster_pkg::*;
#(
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [AREA_W-1:0]  area_i,
  input  logic [DELTA_W-1:0] dl_w0_col_i,
  input  logic [DELTA_W-1:0] dl_w1_col_i,
  input  logic [DELTA_W-1:0] dl_w2_col_i,
  input  logic [DELTA_W-1:0] dl_w0_row_i,
  input  logic [DELTA_W-1:0] dl_w1_row_i,
  input  logic [DELTA_W-1:0] dl_w2_row_i,
  input  logic [EDGE_W-1:0]  w0_row_i,
  input  logic [EDGE_W-1:0]  w1_row_i,
  input  logic [EDGE_W-1:0]  w2_row_i,
  input  logic [COORD_W-1:0] x_min_i,
  input  logic [COORD_W-1:0] y_min_i,
  input  logic [COORD_W-1:0] x_max_i,
  input  logic [COORD_W-1:0] y_max_i,
  input  logic               valid_i,
  output logic               busy_o,
  output logic [COORD_W-1:0] frag_x_o,
  output logic [COORD_W-1:0] frag_y_o,
  output logic [EDGE_W-1:0]  frag_w0_o,
  output logic [EDGE_W-1:0]  frag_w1_o,
  output logic [EDGE_W-1:0]  frag_w2_o,
  output logic [AREA_W-1:0]  frag_area_o,
  output logic               valid_o,
  input  logic               busy_i
);

  trav_state_e        r_state;
  trav_state_e        w_state_next;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] r_x_min;
  logic [COORD_W-1:0] r_x_max;
  logic [COORD_W-1:0] r_y_max;
  logic [AREA_W-1:0]  r_area;
  fragment_t          r_frag;
  logic               r_valid;

  logic               w_accept;
  logic               w_degen;
  logic               w_slot_free;
  logic               w_step;
  logic               w_x_last;
  logic               w_y_last;
  logic               w_step_col;
  logic               w_step_row;
  logic               w_covered;
  logic               w_onscreen;
  logic [EDGE_W-1:0]  w_w0;
  logic [EDGE_W-1:0]  w_w1;
  logic [EDGE_W-1:0]  w_w2;

  assign busy_o      = (r_state != IDLE);
  assign w_accept    = valid_i & (r_state == IDLE);
  assign w_degen     = (area_i == '0) ||
                       ($signed(x_min_i) > $signed(x_max_i)) ||
                       ($signed(y_min_i) > $signed(y_max_i));
  assign w_slot_free = !r_valid || !busy_i;
  assign w_step      = (r_state == TRAVERSE) && w_slot_free;
  assign w_x_last    = (r_x == r_x_max);
  assign w_y_last    = (r_y == r_y_max);
  assign w_step_col  = w_step && !w_x_last;
  assign w_step_row  = w_step && w_x_last && !w_y_last;
  assign w_covered   = !w_w0[EDGE_W-1] && !w_w1[EDGE_W-1] && !w_w2[EDGE_W-1];
  // Once the sign bit is clear, an unsigned compare against the screen size is exact.
  assign w_onscreen  = !r_x[COORD_W-1] && !r_y[COORD_W-1] &&
                       (r_x < COORD_W'(SCREEN_W)) && (r_y < COORD_W'(SCREEN_H));

  edge_stepper u_edge0 (
    .clock_i   (clock_i),
    .load_i    (w_accept),
    .step_col_i(w_step_col),
    .step_row_i(w_step_row),
    .w_init_i  (w0_row_i),
    .dl_col_i  (dl_w0_col_i),
    .dl_row_i  (dl_w0_row_i),
    .w_o       (w_w0)
  );

  edge_stepper u_edge1 (
    .clock_i   (clock_i),
    .load_i    (w_accept),
    .step_col_i(w_step_col),
    .step_row_i(w_step_row),
    .w_init_i  (w1_row_i),
    .dl_col_i  (dl_w1_col_i),
    .dl_row_i  (dl_w1_row_i),
    .w_o       (w_w1)
  );

  edge_stepper u_edge2 (
    .clock_i   (clock_i),
    .load_i    (w_accept),
    .step_col_i(w_step_col),
    .step_row_i(w_step_row),
    .w_init_i  (w2_row_i),
    .dl_col_i  (dl_w2_col_i),
    .dl_row_i  (dl_w2_row_i),
    .w_o       (w_w2)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:     if (valid_i && !w_degen) w_state_next = TRAVERSE;
      TRAVERSE: if (w_step && w_x_last && w_y_last) w_state_next = IDLE;
      default:  w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_slot_free) r_valid <= w_step && w_covered && w_onscreen;
    end
  end

  // Degenerate triangles still load here; harmless since the FSM stays idle.
  always_ff @(posedge clock_i) begin
    if (w_accept) begin
      r_x     <= x_min_i;
      r_y     <= y_min_i;
      r_x_min <= x_min_i;
      r_x_max <= x_max_i;
      r_y_max <= y_max_i;
      r_area  <= area_i;
    end else if (w_step) begin
      if (!w_x_last) begin
        r_x <= r_x + 1'b1;
      end else if (!w_y_last) begin
        r_x <= r_x_min;
        r_y <= r_y + 1'b1;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (w_step) begin
      r_frag <= '{x: r_x, y: r_y, w0: w_w0, w1: w_w1, w2: w_w2, area: r_area};
    end
  end

  assign valid_o     = r_valid;
  assign frag_x_o    = r_frag.x;
  assign frag_y_o    = r_frag.y;
  assign frag_w0_o   = r_frag.w0;
  assign frag_w1_o   = r_frag.w1;
  assign frag_w2_o   = r_frag.w2;
  assign frag_area_o = r_frag.area;

endmodule
